// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reset constants and the fetch state encoding.
package cpu_pkg;

   localparam logic [3:0]  OPC_HLT  = 4'hF;
   localparam logic [15:0] NOP      = 16'h0000;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] PC_STEP  = 16'h0002;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } fetchState_t;

   function automatic logic isHlt(input logic [15:0] instr);
      return instr[15:12] == OPC_HLT;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear squashes to a NOP bubble, enable loads a valid instruction.
module ifid_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   input  logic [15:0] instrIn,
   input  logic [15:0] pcPlus2In,
   output logic [15:0] instr,
   output logic [15:0] pcPlus2,
   output logic        valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr   <= NOP;
         pcPlus2 <= 16'h0000;
         valid   <= 1'b0;
      end else if (clr) begin
         instr   <= NOP;
         pcPlus2 <= 16'h0000;
         valid   <= 1'b0;
      end else if (en) begin
         instr   <= instrIn;
         pcPlus2 <= pcPlus2In;
         valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory and fills IF/ID,
// handling stall, flush/redirect and HLT.
module fetch_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_data,
   output logic [15:0] pc,
   output logic [15:0] instr_if_id,
   output logic [15:0] pc_plus2_if_id,
   output logic        valid_if_id,
   output logic        hlt_fetched
);

   fetchState_t state;
   logic [15:0] pcQ;
   logic [15:0] pcPlus2;
   logic        pending;
   logic [15:0] redirectPc;
   logic [15:0] holdInstr;
   logic [15:0] holdPcPlus2;
   logic        reqQ;
   logic        hltQ;
   logic        fire;

   logic        ifidEn;
   logic        ifidClr;
   logic [15:0] ifidInstrIn;
   logic [15:0] ifidPcPlus2In;

   assign pcPlus2     = pcQ + PC_STEP;
   assign fire        = (state == FETCH) && reqQ && imem_ready;
   assign pc          = pcQ;
   assign imem_addr   = pcQ;
   assign imem_req    = reqQ;
   assign hlt_fetched = hltQ;

   // IF/ID control: flush > stall (hold) > new load > bubble.
   always_comb begin
      ifidEn        = 1'b0;
      ifidClr       = 1'b0;
      ifidInstrIn   = imem_data;
      ifidPcPlus2In = pcPlus2;
      if (flush) begin
         ifidClr = 1'b1;
      end else if (stall) begin
         ifidEn = 1'b0;
      end else if (fire && !pending) begin
         ifidEn = 1'b1;
      end else if (state == HOLD) begin
         ifidEn        = 1'b1;
         ifidInstrIn   = holdInstr;
         ifidPcPlus2In = holdPcPlus2;
      end else begin
         ifidClr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pcQ         <= RESET_PC;
         pending     <= 1'b0;
         redirectPc  <= RESET_PC;
         holdInstr   <= NOP;
         holdPcPlus2 <= 16'h0000;
         reqQ        <= 1'b0;
         hltQ        <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               reqQ <= 1'b1;
               if (fire) begin
                  if (flush) begin
                     pcQ     <= branch_target;
                     pending <= 1'b0;
                  end else if (pending) begin
                     // Response belongs to the squashed path; drop it and redirect.
                     pcQ     <= redirectPc;
                     pending <= 1'b0;
                  end else if (stall) begin
                     holdInstr   <= imem_data;
                     holdPcPlus2 <= pcPlus2;
                     pcQ         <= pcPlus2;
                     state       <= HOLD;
                     reqQ        <= 1'b0;
                  end else begin
                     pcQ <= pcPlus2;
                     if (isHlt(imem_data)) begin
                        state <= HALT;
                        reqQ  <= 1'b0;
                        hltQ  <= 1'b1;
                     end
                  end
               end else if (flush) begin
                  if (reqQ) begin
                     // Request stays up until its response arrives.
                     redirectPc <= branch_target;
                     pending    <= 1'b1;
                  end else begin
                     pcQ <= branch_target;
                  end
               end
            end
            HOLD: begin
               if (flush) begin
                  pcQ     <= branch_target;
                  pending <= 1'b0;
                  state   <= FETCH;
                  reqQ    <= 1'b1;
               end else if (!stall) begin
                  if (isHlt(holdInstr)) begin
                     state <= HALT;
                     hltQ  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     reqQ  <= 1'b1;
                  end
               end
            end
            HALT: begin
               if (flush) begin
                  pcQ     <= branch_target;
                  pending <= 1'b0;
                  state   <= FETCH;
                  reqQ    <= 1'b1;
                  hltQ    <= 1'b0;
               end
            end
            default: begin
               state <= FETCH;
               reqQ  <= 1'b0;
               hltQ  <= 1'b0;
            end
         endcase
      end
   end

   ifid_reg u_ifid_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (ifidEn),
      .clr       (ifidClr),
      .instrIn   (ifidInstrIn),
      .pcPlus2In (ifidPcPlus2In),
      .instr     (instr_if_id),
      .pcPlus2   (pc_plus2_if_id),
      .valid     (valid_if_id)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a switchable auto/manual memory model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;
   logic [15:0] pc;
   logic [15:0] instr_if_id;
   logic [15:0] pc_plus2_if_id;
   logic        valid_if_id;
   logic        hlt_fetched;

   logic        memAuto;
   logic        manReady;
   logic [15:0] manData;
   logic [15:0] hltAddr;
   logic [15:0] autoData;

   int checks;
   int errors;

   // Auto mode: single-cycle memory, word at addr = 0x1000 + addr/2, HLT at hltAddr.
   assign autoData   = (imem_addr == hltAddr) ? 16'hF000 : 16'h1000 + {1'b0, imem_addr[15:1]};
   assign imem_ready = memAuto ? imem_req : manReady;
   assign imem_data  = memAuto ? autoData : manData;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_data      (imem_data),
      .pc             (pc),
      .instr_if_id    (instr_if_id),
      .pc_plus2_if_id (pc_plus2_if_id),
      .valid_if_id    (valid_if_id),
      .hlt_fetched    (hlt_fetched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic autoMode);
      rst_n         = 1'b0;
      memAuto       = autoMode;
      manReady      = 1'b0;
      manData       = 16'h0000;
      hltAddr       = 16'h0001;
      stall         = 1'b0;
      flush         = 1'b0;
      branch_target = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      doReset(1'b1);
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h exp 0000", pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      checks++; if (instr_if_id !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h exp 0000", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0000) begin errors++; $display("FAIL rst_pc2: got %h exp 0000", pc_plus2_if_id); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_if_id); end
      checks++; if (hlt_fetched !== 1'b0) begin errors++; $display("FAIL rst_hlt: got %b exp 0", hlt_fetched); end
   endtask

   task automatic test_back_to_back();
      doReset(1'b1);
      step();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req_rise: got %b exp 1", imem_req); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL b2b_valid1: got %b exp 0", valid_if_id); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL b2b_addr0: got %h exp 0000", imem_addr); end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (valid_if_id !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b exp 1", i, valid_if_id); end
         checks++; if (instr_if_id !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL b2b_instr[%0d]: got %h exp %h", i, instr_if_id, 16'h1000 + 16'(i)); end
         checks++; if (pc_plus2_if_id !== 16'(2 * (i + 1))) begin errors++; $display("FAIL b2b_pc2[%0d]: got %h exp %h", i, pc_plus2_if_id, 16'(2 * (i + 1))); end
         checks++; if (pc !== 16'(2 * (i + 1))) begin errors++; $display("FAIL b2b_pc[%0d]: got %h exp %h", i, pc, 16'(2 * (i + 1))); end
      end
   endtask

   task automatic test_latency();
      doReset(1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL lat_addr[%0d]: got %h exp 0000", i, imem_addr); end
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d]: got %b exp 1", i, imem_req); end
         checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL lat_valid[%0d]: got %b exp 0", i, valid_if_id); end
         if (i == 2) begin
            manReady = 1'b1;
            manData  = 16'h1234;
         end
         step();
      end
      manReady = 1'b0;
      checks++; if (valid_if_id !== 1'b1) begin errors++; $display("FAIL lat_valid_out: got %b exp 1", valid_if_id); end
      checks++; if (instr_if_id !== 16'h1234) begin errors++; $display("FAIL lat_instr: got %h exp 1234", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0002) begin errors++; $display("FAIL lat_pc2: got %h exp 0002", pc_plus2_if_id); end
      checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL lat_pc: got %h exp 0002", pc); end
   endtask

   task automatic test_stall();
      manReady = 1'b1;
      manData  = 16'h2222;
      stall    = 1'b1;
      step();
      manReady = 1'b0;
      checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL stl_pc: got %h exp 0004", pc); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_req[%0d]: got %b exp 0", i, imem_req); end
         checks++; if (instr_if_id !== 16'h1234) begin errors++; $display("FAIL stl_frozen[%0d]: got %h exp 1234", i, instr_if_id); end
         checks++; if (valid_if_id !== 1'b1) begin errors++; $display("FAIL stl_valid[%0d]: got %b exp 1", i, valid_if_id); end
         if (i < 3) step();
      end
      stall = 1'b0;
      step();
      checks++; if (instr_if_id !== 16'h2222) begin errors++; $display("FAIL stl_release_instr: got %h exp 2222", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0004) begin errors++; $display("FAIL stl_release_pc2: got %h exp 0004", pc_plus2_if_id); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stl_release_req: got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stl_release_addr: got %h exp 0004", imem_addr); end
      manReady = 1'b1;
      manData  = 16'h3333;
      step();
      manReady = 1'b0;
      checks++; if (instr_if_id !== 16'h3333) begin errors++; $display("FAIL stl_next_instr: got %h exp 3333", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0006) begin errors++; $display("FAIL stl_next_pc2: got %h exp 0006", pc_plus2_if_id); end
   endtask

   task automatic test_flush();
      manReady      = 1'b1;
      manData       = 16'h4444;
      flush         = 1'b1;
      branch_target = 16'h0010;
      step();
      flush    = 1'b0;
      manReady = 1'b0;
      checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL fl_ready_pc: got %h exp 0010", pc); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL fl_ready_valid: got %b exp 0", valid_if_id); end
      checks++; if (instr_if_id !== 16'h0000) begin errors++; $display("FAIL fl_ready_nop: got %h exp 0000", instr_if_id); end
      step();
      flush         = 1'b1;
      branch_target = 16'h0030;
      step();
      branch_target = 16'h0040;
      step();
      flush = 1'b0;
      checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL fl_pend_addr: got %h exp 0010", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_pend_req: got %b exp 1", imem_req); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL fl_pend_valid: got %b exp 0", valid_if_id); end
      manReady = 1'b1;
      manData  = 16'h5555;
      step();
      manData = 16'h6666;
      checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL fl_redirect_addr: got %h exp 0040", imem_addr); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL fl_discard_valid: got %b exp 0", valid_if_id); end
      step();
      manReady = 1'b0;
      checks++; if (instr_if_id !== 16'h6666) begin errors++; $display("FAIL fl_new_instr: got %h exp 6666", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0042) begin errors++; $display("FAIL fl_new_pc2: got %h exp 0042", pc_plus2_if_id); end
   endtask

   task automatic test_halt();
      doReset(1'b1);
      hltAddr = 16'h0006;
      repeat (4) step();
      checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL hlt_pc_before: got %h exp 0006", pc); end
      step();
      checks++; if (instr_if_id !== 16'hF000) begin errors++; $display("FAIL hlt_instr: got %h exp f000", instr_if_id); end
      checks++; if (hlt_fetched !== 1'b1) begin errors++; $display("FAIL hlt_flag: got %b exp 1", hlt_fetched); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_req: got %b exp 0", imem_req); end
      repeat (2) begin
         step();
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_req_stays: got %b exp 0", imem_req); end
         checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL hlt_bubble: got %b exp 0", valid_if_id); end
      end
      flush         = 1'b1;
      branch_target = 16'h0020;
      step();
      flush = 1'b0;
      checks++; if (hlt_fetched !== 1'b0) begin errors++; $display("FAIL hlt_resume_flag: got %b exp 0", hlt_fetched); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hlt_resume_req: got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 16'h0020) begin errors++; $display("FAIL hlt_resume_addr: got %h exp 0020", imem_addr); end
      step();
      checks++; if (instr_if_id !== 16'h1010) begin errors++; $display("FAIL hlt_resume_instr: got %h exp 1010", instr_if_id); end
   endtask

   task automatic test_wrap();
      flush         = 1'b1;
      branch_target = 16'hFFFE;
      step();
      flush = 1'b0;
      checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc: got %h exp fffe", pc); end
      step();
      checks++; if (instr_if_id !== 16'h8FFF) begin errors++; $display("FAIL wrap_instr: got %h exp 8fff", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0000) begin errors++; $display("FAIL wrap_pc2: got %h exp 0000", pc_plus2_if_id); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc_after: got %h exp 0000", pc); end
      step();
      checks++; if (instr_if_id !== 16'h1000) begin errors++; $display("FAIL wrap_next: got %h exp 1000", instr_if_id); end
   endtask

   task automatic test_reset_mid();
      doReset(1'b0);
      step();
      manReady = 1'b1;
      manData  = 16'h7777;
      step();
      manReady = 1'b0;
      checks++; if (instr_if_id !== 16'h7777) begin errors++; $display("FAIL rm_load: got %h exp 7777", instr_if_id); end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rm_pc: got %h exp 0000", pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", imem_req); end
      checks++; if (instr_if_id !== 16'h0000) begin errors++; $display("FAIL rm_instr: got %h exp 0000", instr_if_id); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b exp 0", valid_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0000) begin errors++; $display("FAIL rm_pc2: got %h exp 0000", pc_plus2_if_id); end
      manReady = 1'b1;
      manData  = 16'h9999;
      step();
      manReady = 1'b0;
      rst_n    = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_restart_req: got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rm_restart_addr: got %h exp 0000", imem_addr); end
      checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL rm_restart_valid: got %b exp 0", valid_if_id); end
      manReady = 1'b1;
      manData  = 16'h8888;
      step();
      manReady = 1'b0;
      checks++; if (instr_if_id !== 16'h8888) begin errors++; $display("FAIL rm_restart_instr: got %h exp 8888", instr_if_id); end
      checks++; if (pc_plus2_if_id !== 16'h0002) begin errors++; $display("FAIL rm_restart_pc2: got %h exp 0002", pc_plus2_if_id); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_back_to_back();
      test_latency();
      test_stall();
      test_flush();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: stall  input  1  hazard unit: hold IF/ID and stop PC advance.
REQ-004 SHALL have port: flush  input  1  taken branch/redirect: squash IF/ID, refetch from branch_target.
REQ-005 SHALL have port: branch_target  input  16  redirect PC, sampled when flush=1.
REQ-006 SHALL have port: imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port: imem_addr  output  16  fetch address, equals pc.
REQ-008 SHALL have port: imem_ready  input  1  imem_data valid this cycle; variable latency, 1..N cycles.
REQ-009 SHALL have port: imem_data  input  16  fetched instruction.
REQ-010 SHALL have port: pc  output  16  current fetch PC.
REQ-011 SHALL have port: instr_if_id  output  16  IF/ID instruction register.
REQ-012 SHALL have port: pc_plus2_if_id  output  16  IF/ID PC+2.
REQ-013 SHALL have port: valid_if_id  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port: hlt_fetched  output  1  HLT fetched; fetch stopped.

Function
REQ-015 SHALL implement states FETCH, HOLD, HALT.
REQ-016 FETCH: imem_req=1, imem_addr=pc held stable until imem_ready.
REQ-017 FETCH, imem_ready, no flush, no stall, no pending redirect: IF/ID <= {imem_data, pc+2, valid=1} next edge; pc <= pc+2 (16-bit wrap, 0xFFFE -> 0x0000).
REQ-018 FETCH, imem_ready, stall=1: imem_data and pc+2 captured into hold buffer; pc <= pc+2; go HOLD; IF/ID unchanged.
REQ-019 HOLD: imem_req=0; when stall=0, IF/ID <= hold buffer, valid=1; go FETCH (or HALT per REQ-021).
REQ-020 flush while FETCH and imem_ready=0: record branch_target in redirect register, set pending; request NOT withdrawn; when imem_ready arrives, response discarded, pc <= recorded target, pending cleared, stay FETCH.
REQ-021 Instruction accepted into IF/ID (direct or from hold buffer) with imem_data[15:12]==OPC_HLT: go HALT after the load; no further requests.
REQ-022 HALT: imem_req=0, hlt_fetched=1; flush -> pc <= branch_target, go FETCH, hlt_fetched=0.
REQ-023 flush in HOLD, or in FETCH with imem_ready=1: data discarded, pc <= branch_target, go FETCH; a later flush overrides an earlier pending target.
REQ-024 IF/ID priority: flush (valid<=0, instr<=NOP) > stall (hold) > new load > bubble (valid<=0).
REQ-025 Response latency: imem_ready in cycle N -> valid_if_id=1 in cycle N+1 when unstalled.
REQ-026 Back-to-back: single-cycle memory SHALL sustain one instruction per cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force pc=RESET_PC (0x0000), state=FETCH, pending=0, instr_if_id=NOP (0x0000), pc_plus2_if_id=0, valid_if_id=0, hlt_fetched=0, imem_req=0.
REQ-028 imem_req SHALL rise on the first edge after rst_n deasserts; reset mid-request abandons the outstanding response.

Structure
REQ-029 OPC_HLT (4'hF), NOP (16'h0000), RESET_PC and the fetch state enum SHALL live in shared package cpu_pkg.
REQ-030 IF/ID register SHALL be sub-module ifid_reg (enable, clear, async reset).

Verification
REQ-031 1-cycle memory, program 0x1000,0x1001,...: valid_if_id from cycle 2, pc 0,2,4,... one per cycle.
REQ-032 3-cycle latency: imem_addr stable at 0x0000 for 3 cycles; IF/ID gets instr one cycle after imem_ready; pc -> 0x0002.
REQ-033 stall=1 for 4 cycles as response arrives: IF/ID frozen, imem_req=0 in HOLD; on release buffered word loads, no instruction lost/duplicated.
REQ-034 flush with target 0x0040 mid-latency at pc 0x0010: that response discarded, next imem_addr=0x0040, valid_if_id=0 meanwhile.
REQ-035 Fetch 0xF000 at 0x0006: hlt_fetched=1, imem_req=0 thereafter; subsequent flush to 0x0020 resumes fetch.
REQ-036 rst_n pulsed low while awaiting imem_ready: outputs at reset values immediately, fetch restarts at 0x0000.
